key_sched_ctrl: RTL
===================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 12, sets the ANUBIS round count; NUM_ROUNDS+1 round keys (indices 0..NUM_ROUNDS) are produced per key.
REQ-002 Parameter PHASES, default 4, sets the number of step_en cycles per round key (gamma, omega, tau, reserve).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key_valid  input  1  cipher-key request; key_ready  output  1  high only in IDLE.
REQ-006 flush  input  1  abort the current schedule.
REQ-007 load_key_o  output  1  one-cycle load strobe to the evolution/selection engines; step_en_o  output  1  clk_en to the engines.
REQ-008 rc_idx_o  output  4  round-constant index for key evolution, equal to the current round index.
REQ-009 rk_in  input  128  selected round key from the selection engine.
REQ-010 rk_out  output  128  registered round key; rk_valid  output  1; rk_ready  input  1; rk_idx  output  4; rk_last  output  1  (rk_idx==NUM_ROUNDS).
REQ-011 replay_req  input  1, rev  input  1  replay the cached keys, with rev=1 giving descending order for decryption.

Function
REQ-012 The FSM states SHALL be IDLE, LOAD, RUN, PRESENT, REPLAY.
REQ-013 IDLE: on key_valid&&key_ready, go to LOAD and clear the round index to 0.
REQ-014 LOAD: assert load_key_o for exactly one cycle, then go to RUN with the phase counter at 0.
REQ-015 RUN: assert step_en_o every cycle for PHASES cycles (phase 0..PHASES-1). On the last phase, go to PRESENT. In the following cycle, rk_out SHALL equal the value of rk_in sampled at the end of the last phase, and rk_valid=1.
REQ-016 The latency from key handshake to the first rk_valid SHALL be 1+PHASES+1 cycles (6 at default).
REQ-017 PRESENT: hold rk_out, rk_idx and rk_valid stable until rk_ready. On handshake with rk_idx<NUM_ROUNDS, increment the index and return to RUN. With rk_idx==NUM_ROUNDS, return to IDLE.
REQ-018 step_en_o SHALL be low in every state except RUN, so the engines freeze while the consumer stalls.
REQ-019 rk_valid SHALL deassert in the cycle after the handshake; back-to-back keys are spaced PHASES+1 cycles apart.
REQ-020 flush in any state SHALL force IDLE next cycle with rk_valid=0, step_en_o=0 and the index cleared. flush wins over a simultaneous rk handshake or key handshake.
REQ-021 key_valid outside IDLE SHALL be ignored, with no queuing.
REQ-022 The round index SHALL never exceed NUM_ROUNDS; no wrap.

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, index=0, phase=0, load_key_o=0, step_en_o=0, rk_valid=0, rk_out=0, rk_idx=0, and invalidate the cache.
REQ-024 Reset mid-schedule SHALL discard all partial results; no key is emitted after release until a new key handshake.

Configuration
REQ-025 The macro KEY_SCHED_CACHE_EN SHALL control the round-key cache.
REQ-026 With KEY_SCHED_CACHE_EN defined:
- Each presented round key SHALL be written into a (NUM_ROUNDS+1)x128 buffer at rk_idx.
- A completed schedule SHALL set cache_valid.
- replay_req in IDLE with cache_valid SHALL enter REPLAY.
- REPLAY emits all keys with the same valid/ready handshake, one per cycle when rk_ready is held high, in index order 0..NUM_ROUNDS (rev=0) or NUM_ROUNDS..0 (rev=1).
- step_en_o and load_key_o stay low during REPLAY.
- rk_last SHALL mark the final key of the replay.
REQ-027 A new key handshake or flush SHALL clear cache_valid.
REQ-028 Without KEY_SCHED_CACHE_EN: no buffer is built, and replay_req and rev are ignored.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding constants, the ANUBIS-128 defaults (NUM_ROUNDS=12, PHASES=4) and the 128-bit key width.
REQ-030 The cache SHALL be a single sub-module rk_cache (write port, read port, index), instantiated only under KEY_SCHED_CACHE_EN.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 Reset, then key handshake at cycle 0 -> load_key_o=1 at cycle 1, step_en_o=1 cycles 2..5, rk_valid=1 with rk_idx=0 at cycle 6.
REQ-033 rk_ready held at 1 -> 13 keys with rk_idx 0..12, spaced 5 cycles apart, rk_last only on idx 12, then key_ready=1.
REQ-034 rk_ready held low 10 cycles at idx 3 -> rk_out/rk_idx stable and step_en_o=0 throughout; resumes idx 4 after the handshake.
REQ-035 flush asserted with rk_ready at idx 7 -> IDLE, rk_valid=0, no idx 8, and a new key restarts at idx 0.
REQ-036 reset pulsed low during RUN phase 2 -> all outputs 0 immediately; key_valid held low afterwards -> no rk_valid.
REQ-037 KEY_SCHED_CACHE_EN, full schedule then replay_req with rev=1 and rk_ready=1 -> 13 consecutive-cycle keys idx 12..0 matching the originals, step_en_o=0 throughout.

Source files
------------

// File: rtl/key_sched_ctrl_pkg.sv
// Shared definitions for the ANUBIS key-schedule controller.
//   - FSM state encoding
//   - ANUBIS-128 defaults: 12 rounds, 4 engine phases per round key
//   - key / round-key width and round-index width
package key_sched_ctrl_pkg;

    localparam int KEY_W         = 128;
    localparam int IDX_W         = 4;
    localparam int ANUBIS_ROUNDS = 12;
    localparam int ANUBIS_PHASES = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_PRESENT = 3'd3,
        S_REPLAY  = 3'd4
    } state_t;

endpackage

// File: rtl/key_sched_ctrl_cache.sv
// rk_cache: round-key buffer, one 128-bit entry per round index.
// No reset on the storage; validity is tracked by the controller.
// Ports:
//   clk      - clock
//   wr_en    - write strobe, wr_idx/wr_data written on the rising edge
//   rd_idx   - read index, rd_data is combinational from the array
module rk_cache
    import key_sched_ctrl_pkg::*;
#(
    parameter int DEPTH = ANUBIS_ROUNDS + 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_data
);

    logic [KEY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: sequences the ANUBIS key-evolution / selection engines.
// A key handshake loads the engines, then each round key takes PHASES
// step_en cycles before it is registered and offered on rk_out with a
// valid/ready handshake. step_en_o is only high in RUN, so a stalled
// consumer freezes the engines.
// Optional feature (macro KEY_SCHED_CACHE_EN): round keys are cached and
// can be replayed forward (rev=0) or backward (rev=1) with replay_req.
// Ports:
//   clk, reset            - clock, async active-low reset
//   key_valid/key_ready   - cipher-key request (ready only in IDLE)
//   flush                 - abort schedule, back to IDLE
//   load_key_o, step_en_o - engine load strobe and clock enable
//   rc_idx_o              - round-constant index (= current round)
//   rk_in                 - round key from the selection engine
//   rk_out/rk_valid/rk_ready/rk_idx/rk_last - round-key output stream
//   replay_req, rev       - cache replay request and direction
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = ANUBIS_ROUNDS,
    parameter int PHASES     = ANUBIS_PHASES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             flush,
    output logic             load_key_o,
    output logic             step_en_o,
    output logic [IDX_W-1:0] rc_idx_o,
    input  logic [KEY_W-1:0] rk_in,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    input  logic             replay_req,
    input  logic             rev
);

    localparam int               PH_W     = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(PHASES - 1);

    state_t           state, state_nx;
    logic [PH_W-1:0]  phase, phase_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             capture;   // last phase done: register rk_in
    logic             last_nx;

`ifdef KEY_SCHED_CACHE_EN
    logic             cache_valid, cache_set, cache_clr;
    logic             rev_q, rev_nx;
    logic             fetch;     // load rk_out from the cache at idx_nx
    logic [KEY_W-1:0] cache_data;

    rk_cache #(.DEPTH(NUM_ROUNDS + 1)) u_cache (
        .clk     (clk),
        .wr_en   (capture),
        .wr_idx  (idx),
        .wr_data (rk_in),
        .rd_idx  (idx_nx),
        .rd_data (cache_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid <= 1'b0;
            rev_q       <= 1'b0;
        end else begin
            rev_q <= rev_nx;
            if (cache_clr)      cache_valid <= 1'b0;
            else if (cache_set) cache_valid <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{replay_req, rev};
`endif

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        idx_nx   = idx;
        capture  = 1'b0;
        last_nx  = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
        rev_nx    = rev_q;
        fetch     = 1'b0;
        cache_set = 1'b0;
        cache_clr = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (key_valid) begin
                    state_nx = S_LOAD;
                    idx_nx   = '0;
`ifdef KEY_SCHED_CACHE_EN
                    cache_clr = 1'b1;
                end else if (replay_req && cache_valid) begin
                    state_nx = S_REPLAY;
                    rev_nx   = rev;
                    idx_nx   = rev ? LAST_IDX : {IDX_W{1'b0}};
                    fetch    = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                state_nx = S_RUN;
                phase_nx = '0;
            end
            S_RUN: begin
                if (phase == LAST_PH) begin
                    state_nx = S_PRESENT;
                    capture  = 1'b1;
                end else begin
                    phase_nx = phase + 1'b1;
                end
            end
            S_PRESENT: begin
                if (rk_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_IDLE;
`ifdef KEY_SCHED_CACHE_EN
                        cache_set = 1'b1;
`endif
                    end else begin
                        state_nx = S_RUN;
                        idx_nx   = idx + 1'b1;
                        phase_nx = '0;
                    end
                end
            end
`ifdef KEY_SCHED_CACHE_EN
            S_REPLAY: begin
                if (rk_ready) begin
                    if (idx == (rev_q ? {IDX_W{1'b0}} : LAST_IDX)) begin
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx = rev_q ? idx - 1'b1 : idx + 1'b1;
                        fetch  = 1'b1;
                    end
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase

        // flush overrides any handshake taken above
        if (flush) begin
            state_nx = S_IDLE;
            phase_nx = '0;
            idx_nx   = '0;
            capture  = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
            fetch     = 1'b0;
            cache_set = 1'b0;
            cache_clr = 1'b1;
`endif
        end

        if (state_nx == S_PRESENT) last_nx = (idx_nx == LAST_IDX);
`ifdef KEY_SCHED_CACHE_EN
        if (state_nx == S_REPLAY)
            last_nx = (idx_nx == (rev_nx ? {IDX_W{1'b0}} : LAST_IDX));
`endif
    end

    // every output is a flop loaded from the next-state decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= '0;
            idx        <= '0;
            key_ready  <= 1'b1;
            load_key_o <= 1'b0;
            step_en_o  <= 1'b0;
            rc_idx_o   <= '0;
            rk_out     <= '0;
            rk_valid   <= 1'b0;
            rk_idx     <= '0;
            rk_last    <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            idx        <= idx_nx;
            key_ready  <= (state_nx == S_IDLE);
            load_key_o <= (state_nx == S_LOAD);
            step_en_o  <= (state_nx == S_RUN);
            rc_idx_o   <= idx_nx;
            rk_idx     <= idx_nx;
            rk_valid   <= (state_nx == S_PRESENT) || (state_nx == S_REPLAY);
            rk_last    <= last_nx;
            if (capture) rk_out <= rk_in;
`ifdef KEY_SCHED_CACHE_EN
            else if (fetch) rk_out <= cache_data;
`endif
        end
    end

endmodule
